// File: rtl/adder_pkg.sv
// adder_pkg: shared stage-count and latency helpers for the pipelined Sklansky adders
package adder_pkg;

  function automatic int skla_gp(input int width);
    return (width > 1) ? $clog2(width) : 0;
  endfunction

  function automatic int skla_stages(input int width, input int lvl);
    return (skla_gp(width) + lvl - 1) / lvl;
  endfunction

  function automatic int skla_latency(input int width, input int lvl);
    return skla_stages(width, lvl) + 2;
  endfunction

  // Index of the last prefix level evaluated before the register of prefix stage k
  function automatic int skla_last_level(input int k, input int lvl, input int gp);
    return ((k * lvl < gp) ? k * lvl : gp) - 1;
  endfunction

endpackage

// File: rtl/adder_skla_pipe_if.sv
// adder_skla_pipe_if: input and result valid/ready streams of the pipelined adder
interface adder_skla_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 1
);
  logic                 s_valid;
  logic                 s_ready;
  logic [WIDTH-1:0]     s_a;
  logic [WIDTH-1:0]     s_b;
  logic                 s_ci;
  logic                 s_sub;
  logic [TAG_WIDTH-1:0] s_tag;
  logic                 m_valid;
  logic                 m_ready;
  logic [WIDTH-1:0]     m_sum;
  logic                 m_co;
  logic                 m_ovf;
  logic [TAG_WIDTH-1:0] m_tag;

  modport master (
    output s_valid, s_a, s_b, s_ci, s_sub, s_tag, m_ready,
    input  s_ready, m_valid, m_sum, m_co, m_ovf, m_tag
  );

  modport slave (
    input  s_valid, s_a, s_b, s_ci, s_sub, s_tag, m_ready,
    output s_ready, m_valid, m_sum, m_co, m_ovf, m_tag
  );
endinterface

// File: rtl/adder_skla_pipe_level.sv
// adder_skla_level: one combinational Sklansky level; bits with bit LEVEL set absorb the top of the lower block
module adder_skla_level #(
  parameter int WIDTH = 32,
  parameter int LEVEL = 0
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] g_in,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] g_out
);
  for (genvar j = 0; j < WIDTH; j++) begin : g_bit
    if (((j >> LEVEL) & 1) == 1) begin : g_comb
      localparam int LO = (j | ((1 << LEVEL) - 1)) - (1 << LEVEL);
      assign g_out[j] = g_in[j] | (p_in[j] & g_in[LO]);
      assign p_out[j] = p_in[j] & p_in[LO];
    end else begin : g_pass
      assign g_out[j] = g_in[j];
      assign p_out[j] = p_in[j];
    end
  end
endmodule

// File: rtl/adder_skla_pipe.sv
// adder_skla_pipe: Sklansky prefix adder/subtractor, registered every LVL_PER_STAGE levels, lock-step valid/ready
module adder_skla_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int LVL_PER_STAGE = 2,
  parameter int TAG_WIDTH     = 1
) (
  input logic              clk,
  input logic              resetn,
  adder_skla_pipe_if.slave bus
);
  localparam int GP = skla_gp(WIDTH);
  localparam int N  = skla_stages(WIDTH, LVL_PER_STAGE);
  localparam int NL = (GP > 0) ? GP : 1;
  localparam int NP = (N > 1) ? N - 1 : 0;

  logic                          en;
  logic [WIDTH-1:0]              b_eff;
  logic [WIDTH-1:0]              p_in0;
  logic [WIDTH-1:0]              g_in0;
  logic                          c_in0;
  logic [N:0]                    v_q, v_d, cin_q, cin_d, am_q, am_d, bm_q, bm_d;
  logic [N:0][WIDTH-1:0]         p0_q, p0_d, g_q, g_d;
  logic [NP:0][WIDTH-1:0]        p_q, p_d;
  logic [N:0][TAG_WIDTH-1:0]     tag_q, tag_d;
  logic [NL-1:0][WIDTH-1:0]      li_p, li_g, lo_p, lo_g;
  logic [WIDTH:0]                carry;
  logic [WIDTH-1:0]              sum_d, m_sum_q;
  logic                          ovf_d, m_valid_q, m_co_q, m_ovf_q;
  logic [TAG_WIDTH-1:0]          m_tag_q;

  assign en          = !m_valid_q | bus.m_ready;
  assign bus.s_ready = en;
  assign b_eff       = bus.s_b ^ {WIDTH{bus.s_sub}};
  assign c_in0       = bus.s_ci ^ bus.s_sub;
  assign p_in0       = bus.s_a ^ b_eff;
  assign g_in0       = (bus.s_a & b_eff) | WIDTH'(p_in0[0] & c_in0);

  // Levels at a stage boundary read the stage register, the rest chain combinationally
  for (genvar i = 0; i < GP; i++) begin : g_lvl
    if (i % LVL_PER_STAGE == 0) begin : g_head
      assign li_p[i] = p_q[i / LVL_PER_STAGE];
      assign li_g[i] = g_q[i / LVL_PER_STAGE];
    end else begin : g_chain
      assign li_p[i] = lo_p[i - 1];
      assign li_g[i] = lo_g[i - 1];
    end
    adder_skla_level #(.WIDTH(WIDTH), .LEVEL(i)) u_lvl (
      .p_in (li_p[i]),
      .g_in (li_g[i]),
      .p_out(lo_p[i]),
      .g_out(lo_g[i])
    );
  end

  always_comb begin
    v_d      = '0;
    cin_d    = '0;
    am_d     = '0;
    bm_d     = '0;
    p0_d     = '0;
    g_d      = '0;
    p_d      = '0;
    tag_d    = '0;
    v_d[0]   = bus.s_valid;
    cin_d[0] = c_in0;
    am_d[0]  = bus.s_a[WIDTH-1];
    bm_d[0]  = b_eff[WIDTH-1];
    p0_d[0]  = p_in0;
    g_d[0]   = g_in0;
    p_d[0]   = p_in0;
    tag_d[0] = bus.s_tag;
    for (int k = 1; k <= N; k++) begin
      v_d[k]   = v_q[k-1];
      cin_d[k] = cin_q[k-1];
      am_d[k]  = am_q[k-1];
      bm_d[k]  = bm_q[k-1];
      p0_d[k]  = p0_q[k-1];
      tag_d[k] = tag_q[k-1];
      g_d[k]   = lo_g[skla_last_level(k, LVL_PER_STAGE, GP)];
    end
    for (int k = 1; k <= NP; k++) p_d[k] = lo_p[skla_last_level(k, LVL_PER_STAGE, GP)];
  end

  // G[j] is the carry out of bit j, so the carry vector is G shifted up over cin
  assign carry = {g_q[N], cin_q[N]};
  assign sum_d = p0_q[N] ^ carry[WIDTH-1:0];
  assign ovf_d = (am_q[N] == bm_q[N]) & (sum_d[WIDTH-1] != am_q[N]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_q       <= '0;
      cin_q     <= '0;
      am_q      <= '0;
      bm_q      <= '0;
      p0_q      <= '0;
      g_q       <= '0;
      p_q       <= '0;
      tag_q     <= '0;
      m_valid_q <= 1'b0;
      m_sum_q   <= '0;
      m_co_q    <= 1'b0;
      m_ovf_q   <= 1'b0;
      m_tag_q   <= '0;
    end else if (en) begin
      v_q       <= v_d;
      cin_q     <= cin_d;
      am_q      <= am_d;
      bm_q      <= bm_d;
      p0_q      <= p0_d;
      g_q       <= g_d;
      p_q       <= p_d;
      tag_q     <= tag_d;
      m_valid_q <= v_q[N];
      if (v_q[N]) begin
        m_sum_q <= sum_d;
        m_co_q  <= carry[WIDTH];
        m_ovf_q <= ovf_d;
        m_tag_q <= tag_q[N];
      end
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_sum   = m_sum_q;
  assign bus.m_co    = m_co_q;
  assign bus.m_ovf   = m_ovf_q;
  assign bus.m_tag   = m_tag_q;
endmodule
